// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle RV32I control FSM: states, opcodes,
// ALU operand/operation selects and the packed control-word layout.
package ctrl_pkg;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_MEM_ADDR = 4'd3;
  localparam logic [3:0] S_MEM_RD   = 4'd4;
  localparam logic [3:0] S_MEM_WB   = 4'd5;
  localparam logic [3:0] S_MEM_WR   = 4'd6;
  localparam logic [3:0] S_EXEC_R   = 4'd7;
  localparam logic [3:0] S_EXEC_I   = 4'd8;
  localparam logic [3:0] S_ALU_WB   = 4'd9;
  localparam logic [3:0] S_BRANCH   = 4'd10;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_REGA  = 2'b01;
  localparam logic [1:0] SRCA_OLDPC = 2'b10;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteCond;
    logic       iOrD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       memToReg;
    logic       regWrite;
    logic [1:0] aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic       pcSrc;
    logic       illegalInstr;
  } ctrl_t;

  function automatic logic isSupported(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH: isSupported = 1'b1;
      default:                                          isSupported = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_perf_counters.sv
// Free-running cycle and retired-instruction counters for the control FSM.
// Only instantiated when CTRL_PERF_EN is defined.
module ctrl_perf_counters
  import ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        countCycle,
  input  logic        countInstr,
  output logic [31:0] cycleCount,
  output logic [31:0] instrCount
);

  // Busy-cycle counter, wraps naturally at 2^32
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycleCount <= 32'd0;
    end else if (countCycle) begin
      cycleCount <= cycleCount + 32'd1;
    end else begin
      cycleCount <= cycleCount;
    end
  end

  // Completed-instruction counter, wraps naturally at 2^32
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instrCount <= 32'd0;
    end else if (countInstr) begin
      instrCount <= instrCount + 32'd1;
    end else begin
      instrCount <= instrCount;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle RV32I core (Moore outputs, FETCH writes
// qualified by mem_ready). Optional perf counters under CTRL_PERF_EN.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int RESET_IDLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic        pc_src,
  output logic        illegal_instr,
  output logic [3:0]  state_o
`ifdef CTRL_PERF_EN
  ,
  output logic [31:0] cycle_count,
  output logic [31:0] instr_count
`endif
);

  localparam logic [3:0] IDLE_LAST = 4'(RESET_IDLE_CYCLES - 1);

  logic [3:0] state;
  logic [3:0] nextState;
  logic [3:0] idleCnt;
  ctrl_t      ctrl;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Post-reset idle counter; held at zero outside IDLE so re-entry restarts it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idleCnt <= 4'd0;
    end else if (state == S_IDLE && idleCnt != IDLE_LAST) begin
      idleCnt <= idleCnt + 4'd1;
    end else begin
      idleCnt <= 4'd0;
    end
  end

  // Next-state logic
  always_comb begin
    nextState = S_IDLE;
    case (state)
      S_IDLE:     nextState = (idleCnt == IDLE_LAST) ? S_FETCH : S_IDLE;
      S_FETCH:    nextState = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: nextState = S_MEM_ADDR;
          OP_RTYPE:          nextState = S_EXEC_R;
          OP_ITYPE:          nextState = S_EXEC_I;
          OP_BRANCH:         nextState = S_BRANCH;
          default:           nextState = S_FETCH;
        endcase
      end
      S_MEM_ADDR: begin
        case (opcode)
          OP_LOAD:  nextState = S_MEM_RD;
          OP_STORE: nextState = S_MEM_WR;
          default:  nextState = S_FETCH;
        endcase
      end
      S_MEM_RD:   nextState = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB:   nextState = S_FETCH;
      S_MEM_WR:   nextState = mem_ready ? S_FETCH : S_MEM_WR;
      S_EXEC_R:   nextState = S_ALU_WB;
      S_EXEC_I:   nextState = S_ALU_WB;
      S_ALU_WB:   nextState = S_FETCH;
      S_BRANCH:   nextState = S_FETCH;
      default:    nextState = S_IDLE;
    endcase
  end

  // Output decode; everything not named for a state stays 0
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.memRead = 1'b1;
        ctrl.aluSrcA = SRCA_PC;
        ctrl.aluSrcB = SRCB_FOUR;
        ctrl.aluOp   = ALUOP_ADD;
        ctrl.irWrite = mem_ready;
        ctrl.pcWrite = mem_ready;
      end
      S_DECODE: begin
        ctrl.aluSrcA      = SRCA_OLDPC;
        ctrl.aluSrcB      = SRCB_IMM;
        ctrl.aluOp        = ALUOP_ADD;
        ctrl.illegalInstr = ~isSupported(opcode);
      end
      S_MEM_ADDR: begin
        ctrl.aluSrcA = SRCA_REGA;
        ctrl.aluSrcB = SRCB_IMM;
        ctrl.aluOp   = ALUOP_ADD;
      end
      S_MEM_RD: begin
        ctrl.iOrD    = 1'b1;
        ctrl.memRead = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.regWrite = 1'b1;
        ctrl.memToReg = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.iOrD     = 1'b1;
        ctrl.memWrite = 1'b1;
      end
      S_EXEC_R: begin
        ctrl.aluSrcA = SRCA_REGA;
        ctrl.aluSrcB = SRCB_REGB;
        ctrl.aluOp   = ALUOP_FUNCT;
      end
      S_EXEC_I: begin
        ctrl.aluSrcA = SRCA_REGA;
        ctrl.aluSrcB = SRCB_IMM;
        ctrl.aluOp   = ALUOP_FUNCT;
      end
      S_ALU_WB: begin
        ctrl.regWrite = 1'b1;
        ctrl.memToReg = 1'b0;
      end
      S_BRANCH: begin
        ctrl.aluSrcA     = SRCA_REGA;
        ctrl.aluSrcB     = SRCB_REGB;
        ctrl.aluOp       = ALUOP_SUB;
        ctrl.pcWriteCond = 1'b1;
        ctrl.pcSrc       = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  assign pc_write      = ctrl.pcWrite;
  assign pc_write_cond = ctrl.pcWriteCond;
  assign i_or_d        = ctrl.iOrD;
  assign mem_read      = ctrl.memRead;
  assign mem_write     = ctrl.memWrite;
  assign ir_write      = ctrl.irWrite;
  assign mem_to_reg    = ctrl.memToReg;
  assign reg_write     = ctrl.regWrite;
  assign alu_src_a     = ctrl.aluSrcA;
  assign alu_src_b     = ctrl.aluSrcB;
  assign alu_op        = ctrl.aluOp;
  assign pc_src        = ctrl.pcSrc;
  assign illegal_instr = ctrl.illegalInstr;
  assign state_o       = state;

`ifdef CTRL_PERF_EN
  logic instrDone;

  // Retirement = entering FETCH from a terminal state; illegal returns excluded
  assign instrDone = (nextState == S_FETCH) &&
                     (state == S_MEM_WB || state == S_MEM_WR ||
                      state == S_ALU_WB || state == S_BRANCH);

  ctrl_perf_counters uPerf (
    .clk        (clk),
    .reset      (reset),
    .countCycle (state != S_IDLE),
    .countInstr (instrDone),
    .cycleCount (cycle_count),
    .instrCount (instr_count)
  );
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected state/control
// words are queued as stimulus is driven and compared on the falling edge.
module tb_multicycle_control;
  import ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_write, pc_src, illegal_instr;
  logic [1:0] alu_src_a, alu_src_b, alu_op;
  logic [3:0] state_o;
`ifdef CTRL_PERF_EN
  logic [31:0] cycle_count, instr_count;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  st;
    logic [15:0] ctl;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  multicycle_control #(.RESET_IDLE_CYCLES(1)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
    .illegal_instr(illegal_instr), .state_o(state_o)
`ifdef CTRL_PERF_EN
    , .cycle_count(cycle_count), .instr_count(instr_count)
`endif
  );

  wire [15:0] ctlObs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
                        ir_write, mem_to_reg, reg_write, alu_src_a, alu_src_b,
                        alu_op, pc_src, illegal_instr};

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Independent reference: control word each state must produce
  function automatic logic [15:0] expCtrl(input logic [3:0] st, input logic mr, input logic [6:0] op);
    logic pcw, pcwc, iod, mrd, mwr, irw, m2r, rw, pcs, ill;
    logic [1:0] a, b, o;
    {pcw, pcwc, iod, mrd, mwr, irw, m2r, rw, pcs, ill} = 10'd0;
    a = 2'b00; b = 2'b00; o = 2'b00;
    case (st)
      S_FETCH:    begin mrd = 1'b1; b = 2'b01; irw = mr; pcw = mr; end
      S_DECODE:   begin a = 2'b10; b = 2'b10;
                    ill = !(op == 7'b0000011 || op == 7'b0100011 || op == 7'b0110011 ||
                            op == 7'b0010011 || op == 7'b1100011); end
      S_MEM_ADDR: begin a = 2'b01; b = 2'b10; end
      S_MEM_RD:   begin iod = 1'b1; mrd = 1'b1; end
      S_MEM_WB:   begin rw = 1'b1; m2r = 1'b1; end
      S_MEM_WR:   begin iod = 1'b1; mwr = 1'b1; end
      S_EXEC_R:   begin a = 2'b01; b = 2'b00; o = 2'b10; end
      S_EXEC_I:   begin a = 2'b01; b = 2'b10; o = 2'b10; end
      S_ALU_WB:   begin rw = 1'b1; end
      S_BRANCH:   begin a = 2'b01; o = 2'b01; pcwc = 1'b1; pcs = 1'b1; end
      default:    ;
    endcase
    return {pcw, pcwc, iod, mrd, mwr, irw, m2r, rw, a, b, o, pcs, ill};
  endfunction

  // Scoreboard consumer, sampled mid-cycle
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checkVal("state", {28'd0, state_o}, {28'd0, e.st});
      checkVal("ctrl",  {16'd0, ctlObs},  {16'd0, e.ctl});
    end
  end

  // One clock: drive mem_ready, queue the expectation, advance past the edge
  task automatic cyc(input logic [3:0] st, input logic mr);
    exp_t e;
    mem_ready = mr;
    e.st  = st;
    e.ctl = expCtrl(st, mr, opcode);
    sb.push_back(e);
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic runInstr(input logic [6:0] op, input int fStall, input int mStall);
    opcode = op;
    for (int i = 0; i < fStall; i++) cyc(S_FETCH, 1'b0);
    cyc(S_FETCH, 1'b1);
    cyc(S_DECODE, 1'b1);
    case (op)
      7'b0110011: begin cyc(S_EXEC_R, 1'b1); cyc(S_ALU_WB, 1'b1); end
      7'b0010011: begin cyc(S_EXEC_I, 1'b1); cyc(S_ALU_WB, 1'b1); end
      7'b1100011: cyc(S_BRANCH, 1'b1);
      7'b0000011: begin
        cyc(S_MEM_ADDR, 1'b1);
        for (int i = 0; i < mStall; i++) cyc(S_MEM_RD, 1'b0);
        cyc(S_MEM_RD, 1'b1);
        cyc(S_MEM_WB, 1'b1);
      end
      7'b0100011: begin
        cyc(S_MEM_ADDR, 1'b1);
        for (int i = 0; i < mStall; i++) cyc(S_MEM_WR, 1'b0);
        cyc(S_MEM_WR, 1'b1);
      end
      default: ;
    endcase
  endtask

  task automatic checkAllZero(input string tag);
    checkVal({tag, "_state"}, {28'd0, state_o}, {28'd0, S_IDLE});
    checkVal({tag, "_ctrl"},  {16'd0, ctlObs},  32'd0);
  endtask

  initial begin
    reset = 1'b1; opcode = 7'd0; mem_ready = 1'b0;
    @(posedge clk); #1;
    checkAllZero("rst");
`ifdef CTRL_PERF_EN
    checkVal("rst_cyc", cycle_count, 32'd0);
    checkVal("rst_ins", instr_count, 32'd0);
`endif
    @(posedge clk); #1;
    reset = 1'b0;
    cyc(S_IDLE, 1'b1);

    // R, load, store, illegal back to back with memory always ready
    runInstr(7'b0110011, 0, 0);
    runInstr(7'b0000011, 0, 0);
    runInstr(7'b0100011, 0, 0);
    runInstr(7'b1111111, 0, 0);
    cyc(S_FETCH, 1'b1);
`ifdef CTRL_PERF_EN
    checkVal("perf_cyc", cycle_count, 32'd16);
    checkVal("perf_ins", instr_count, 32'd3);
`endif

    // Stalled load, stalled store, branch, I-type, another illegal
    opcode = 7'b0000011;
    cyc(S_DECODE, 1'b1);
    cyc(S_MEM_ADDR, 1'b1);
    cyc(S_MEM_RD, 1'b1);
    cyc(S_MEM_WB, 1'b1);
    runInstr(7'b0000011, 3, 3);
    runInstr(7'b0100011, 2, 2);
    runInstr(7'b1100011, 0, 0);
    runInstr(7'b0010011, 1, 0);
    runInstr(7'b0000000, 0, 0);

    // Reset mid-MEM_RD must abort asynchronously
    opcode = 7'b0000011;
    cyc(S_FETCH, 1'b1);
    cyc(S_DECODE, 1'b1);
    cyc(S_MEM_ADDR, 1'b1);
    cyc(S_MEM_RD, 1'b0);
    checkVal("pre_rst_st", {28'd0, state_o}, {28'd0, S_MEM_RD});
    mem_ready = 1'b1;
    #2 reset = 1'b1;
    #1 checkAllZero("async_rst");
    @(posedge clk); #1;
    checkAllZero("held_rst");
    reset = 1'b0;
    cyc(S_IDLE, 1'b1);
    runInstr(7'b0110011, 0, 0);
    cyc(S_FETCH, 1'b0);

    repeat (2) @(negedge clk);
    checkVal("sb_drain", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
